// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one async_transmitter among NREQ byte-stream requesters using
// round-robin arbitration. A requester keeps the grant for a whole packet
// (optionally capped at MAX_BURST bytes), each byte is handed to the
// transmitter as a one-cycle tx_start pulse once tx_busy is low, and a
// programmable idle gap follows every released grant so downstream receivers
// see an end-of-packet idle period.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   GAP_CYCLES  forced idle clk cycles after each release (0 = none)
//   MAX_BURST   bytes per grant before forced re-arbitration (0 = unlimited)
//
// Ports
//   clk          in   sole clock
//   rst_n        in   synchronous active-low reset
//   req_valid    in   [NREQ]    lane i holds a byte
//   req_data     in   [8*NREQ]  lane i byte = bits [8i+7:8i]
//   req_last     in   [NREQ]    lane i byte ends its packet
//   req_ack      out  [NREQ]    registered one-cycle accept pulse
//   tx_start     out            to TxD_start, registered
//   tx_data      out  [8]       to TxD_data, registered
//   tx_busy      in             from TxD_busy
//   grant_valid  out            a requester holds the grant
//   grant_id     out  [IDW]     index of the holder
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int  NREQ       = 4,
  parameter int  GAP_CYCLES = 0,
  parameter int  MAX_BURST  = 0,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id
);

  // Counter widths are clamped to at least one bit so the unused-feature
  // configurations (MAX_BURST=0, GAP_CYCLES<=1) still elaborate cleanly.
  localparam int BCW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BURST_CAP = BCW'(MAX_BURST);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Registered state
  state_t            r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [BCW-1:0]    r_burst;
  logic [GCW-1:0]    r_gap_cnt;
  logic              r_last;
  logic              r_grant_valid;
  logic [IDW-1:0]    r_grant_id;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic [NREQ-1:0]   r_req_ack;

  // Next-state values
  state_t            w_state;
  logic [IDW-1:0]    w_rr_ptr;
  logic [BCW-1:0]    w_burst;
  logic [GCW-1:0]    w_gap_cnt;
  logic              w_last;
  logic              w_grant_valid;
  logic [IDW-1:0]    w_grant_id;
  logic              w_tx_start;
  logic [7:0]        w_tx_data;
  logic [NREQ-1:0]   w_req_ack;

  // Arbitration and lane-select helpers
  logic              w_arb_found;
  logic [IDW-1:0]    w_arb_id;
  logic [IDW-1:0]    w_scan_idx;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [7:0]        w_sel_data;
  logic              w_release;

  // Round-robin search: first valid lane at rr_ptr, rr_ptr+1, ... mod NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    w_arb_found = 1'b0;
    w_arb_id    = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_arb_found && req_valid[w_scan_idx]) begin
        w_arb_found = 1'b1;
        w_arb_id    = w_scan_idx;
      end
    end
  end

  // Lane currently owned by the grant holder.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant_id == IDW'(k)) begin
        w_sel_valid = req_valid[k];
        w_sel_last  = req_last[k];
        w_sel_data  = req_data[8*k +: 8];
      end
    end
  end

  // A grant ends on the packet's last byte or when the burst cap is reached.
  assign w_release = r_last || ((MAX_BURST != 0) && (r_burst == BURST_CAP));

  // Next-state and output logic.
  always_comb begin
    w_state       = r_state;
    w_rr_ptr      = r_rr_ptr;
    w_burst       = r_burst;
    w_gap_cnt     = r_gap_cnt;
    w_last        = r_last;
    w_grant_valid = r_grant_valid;
    w_grant_id    = r_grant_id;
    w_tx_data     = r_tx_data;
    w_tx_start    = 1'b0;   // pulses: low unless SEND fires this cycle
    w_req_ack     = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_grant_id    = w_arb_id;
          w_grant_valid = 1'b1;
          w_state       = S_SEND;
        end
      end

      S_SEND: begin
        // Gating on tx_busy keeps tx_start off a busy transmitter, including
        // right after a reset that interrupted a byte in flight.
        if (w_sel_valid && !tx_busy) begin
          w_tx_start = 1'b1;
          w_tx_data  = w_sel_data;
          w_req_ack  = {{(NREQ-1){1'b0}}, 1'b1} << r_grant_id;
          w_last     = w_sel_last;
          w_burst    = r_burst + BCW'(1);
          w_state    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (tx_busy) w_state = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (w_release) begin
            w_rr_ptr      = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + IDW'(1);
            w_burst       = '0;
            w_grant_valid = 1'b0;
            w_gap_cnt     = '0;
            w_state       = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else begin
            w_state = S_SEND;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state = S_IDLE;
        else                       w_gap_cnt = r_gap_cnt + GCW'(1);
      end

      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset clears every register here, pointer and
    // counters included, so a mid-packet reset restarts arbitration cleanly.
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_burst       <= '0;
      r_gap_cnt     <= '0;
      r_last        <= 1'b0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_req_ack     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values sampled at the same edge, independent of statement order.
      r_state       <= w_state;
      r_rr_ptr      <= w_rr_ptr;
      r_burst       <= w_burst;
      r_gap_cnt     <= w_gap_cnt;
      r_last        <= w_last;
      r_grant_valid <= w_grant_valid;
      r_grant_id    <= w_grant_id;
      r_tx_start    <= w_tx_start;
      r_tx_data     <= w_tx_data;
      r_req_ack     <= w_req_ack;
    end
  end

  assign req_ack     = r_req_ack;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Requesters are byte queues presented on their lanes until acknowledged; a
// small transmitter model raises tx_busy the cycle after each tx_start for a
// random duration. A packet-level round-robin model predicts the order of
// transmitted bytes, their grant ids and the start-to-start spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int GAP  = 5;
  localparam int MB   = 3;
  localparam int IDW  = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  uart_tx_scheduler #(
    .NREQ       (NREQ),
    .GAP_CYCLES (GAP),
    .MAX_BURST  (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         first;
  } exp_t;

  // Requester byte stores: {last, data}
  logic [8:0] mem [NREQ][256];
  int         head [NREQ];
  int         tail [NREQ];

  exp_t exp_q[$];
  int   n_exp   = 0;
  int   n_start = 0;
  int   m_ptr   = 0;
  int   cyc     = 0;
  int   ref_cyc = 0;
  int   short_delta = 0;
  int   busy_fixed  = 0;
  bit   arm = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input bit last);
    mem[id][tail[id]] = {last, d};
    tail[id]++;
  endtask

  // Packet-level round robin: pick the first requester with bytes left from
  // the pointer, send until its packet ends or the cap is hit, move past it.
  task automatic run_model();
    int  h [NREQ];
    int  id;
    int  cnt;
    bit  done;
    exp_t e;
    for (int i = 0; i < NREQ; i++) h[i] = head[i];
    forever begin
      id = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (id < 0 && h[j] < tail[j]) id = j;
      end
      if (id < 0) break;
      cnt  = 0;
      done = 1'b0;
      while (!done) begin
        e.id    = id;
        e.data  = mem[id][h[id]][7:0];
        e.first = (cnt == 0);
        exp_q.push_back(e);
        n_exp++;
        cnt++;
        done = mem[id][h[id]][8] || (MB != 0 && cnt == MB) || (h[id] + 1 == tail[id]);
        h[id]++;
      end
      m_ptr = (id + 1) % NREQ;
    end
  endtask

  task automatic start_scenario();
    run_model();
    arm = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || tx_busy) && t < 4000) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (GAP + 6) @(negedge clk);
    #1;
    check("idle_grant_valid", grant_valid, 0);
    check("start_count", n_start, n_exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ack"},     32'(req_ack), 0);
    check({tag, "_tx_start"},    tx_start, 0);
    check({tag, "_tx_data"},     tx_data, 0);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_grant_id"},    32'(grant_id), 0);
  endtask

  // Requesters, transmitter model and per-byte monitor; acts on the falling
  // edge so the DUT's registered outputs are stable when sampled.
  initial begin
    int   busy_cnt;
    int   want;
    exp_t e;
    busy_cnt  = 0;
    tx_busy   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        n_start++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.data);
          check("grant_id", 32'(grant_id), e.id);
          check("req_ack", 32'(req_ack), 1 << e.id);
          check("grant_valid", grant_valid, 1);
          check("busy_at_start", tx_busy, 0);
          want = (short_delta != 0) ? short_delta : (e.first ? GAP + 3 : 2);
          check("start_spacing", cyc - ref_cyc, want);
          short_delta = 0;
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i]) head[i]++;
      if (tx_start) begin
        tx_busy  = 1'b1;
        busy_cnt = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 6));
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_busy = 1'b0;
          ref_cyc = cyc;
        end
      end
      if (arm) begin
        ref_cyc     = cyc;
        short_delta = 2;
        arm         = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]        = (head[i] < tail[i]);
        req_last[i]         = mem[i][head[i]][8];
        req_data[8*i +: 8]  = mem[i][head[i]][7:0];
      end
    end
  end

  initial begin
    int s0;
    int t;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      for (int j = 0; j < 256; j++) mem[i][j] = '0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single requester: three bytes from lane 2.
    push_byte(2, 8'h41, 1'b0);
    push_byte(2, 8'h42, 1'b0);
    push_byte(2, 8'h43, 1'b1);
    start_scenario();
    drain();

    // Every lane one byte: order follows the pointer left by the last grant.
    for (int i = 0; i < NREQ; i++) push_byte(i, 8'h10 + 8'(i), 1'b1);
    start_scenario();
    drain();

    // Packet lock: lane 1's three bytes stay contiguous.
    push_byte(1, 8'h51, 1'b0);
    push_byte(1, 8'h52, 1'b0);
    push_byte(1, 8'h53, 1'b1);
    push_byte(0, 8'h60, 1'b1);
    push_byte(3, 8'h63, 1'b1);
    start_scenario();
    drain();

    // Burst cap: five-byte packet on lane 0 is split, lane 1 interleaves.
    for (int k = 0; k < 5; k++) push_byte(0, 8'h70 + 8'(k), (k == 4));
    push_byte(1, 8'h80, 1'b1);
    start_scenario();
    drain();

    // Random packet mixes.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int k = 0; k < len; k++)
            push_byte(i, 8'($urandom_range(0, 255)), (k == len - 1));
        end
      end
      start_scenario();
      drain();
    end

    // Reset while the transmitter is still busy with a byte.
    busy_fixed = 8;
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b1);
    start_scenario();
    s0 = n_start;
    t  = 0;
    while (n_start == s0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check("rst_first_start", n_start, s0 + 1);
    @(negedge clk); #1;
    check("rst_busy_high", tx_busy, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    n_exp = n_exp - exp_q.size();
    exp_q.delete();
    m_ptr = 0;
    run_model();
    short_delta = 1;
    drain();
    busy_fixed = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
